// File: rtl/fft_frame_packer.sv
// Packs a free-running sample stream into fixed-length complex AXI-Stream frames for the FFT input.
// Optional feature macro: FRAME_FLUSH_EN (adds the flush port and zero-padding of partial frames).
module fft_frame_packer #(
    parameter int IN_W       = 8,
    parameter int OUT_W      = 16,
    parameter int LOG2_NMAX  = 10,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef FRAME_FLUSH_EN
    input  logic                 flush,
`endif
    input  logic [3:0]           cfg_log2n,
    input  logic                 cfg_load,
    input  logic                 s_tvalid,
    input  logic [IN_W-1:0]      s_tdata,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic [2*OUT_W-1:0]   m_tdata,
    output logic                 m_tlast,
    output logic [15:0]          frame_cnt,
    output logic [15:0]          ovf_cnt,
    output logic                 ovf_pulse
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);
    localparam logic [3:0]  NMAX_L  = 4'(LOG2_NMAX);
    localparam logic [3:0]  NMIN_L  = 4'd3;

    // Each FIFO entry carries the sample plus its end-of-frame tag in the MSB.
    logic [IN_W:0]          mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]            count_reg;
    logic [LOG2_NMAX-1:0]   idx_reg;
    logic [3:0]             active_log2n_reg, pend_log2n_reg;
    logic                   pend_valid_reg;
    logic [15:0]            frame_cnt_reg, ovf_cnt_reg;
    logic                   ovf_pulse_reg;

    logic [3:0]             eff_log2n, cfg_clamped;
    logic [LOG2_NMAX-1:0]   last_idx;
    logic                   is_last, rd_fire, has_space, wr_en, drop;
    logic [IN_W-1:0]        wr_sample;
    logic [IN_W:0]          rd_word;
    logic [OUT_W-1:0]       re_ext;

    // A pending length takes over only while idx sits at a frame boundary.
    assign eff_log2n = (pend_valid_reg && idx_reg == '0) ? pend_log2n_reg : active_log2n_reg;

    generate
        for (genvar gi = 0; gi < LOG2_NMAX; gi++) begin : g_last_idx
            assign last_idx[gi] = (eff_log2n > 4'(gi));
        end
    endgenerate

    assign is_last     = (idx_reg == last_idx);
    assign cfg_clamped = (cfg_log2n < NMIN_L) ? NMIN_L :
                         (cfg_log2n > NMAX_L) ? NMAX_L : cfg_log2n;

    assign m_tvalid  = (count_reg != '0);
    assign rd_fire   = m_tvalid && m_tready;
    assign has_space = (count_reg < DEPTH_L) || rd_fire;

`ifdef FRAME_FLUSH_EN
    typedef enum logic {ST_IDLE, ST_PAD} state_t;
    state_t state_reg, state_next;

    always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        wr_en      = 1'b0;
        drop       = 1'b0;
        wr_sample  = s_tdata;
        case (state_reg)
            ST_IDLE: begin
                wr_en = s_tvalid && has_space;
                drop  = s_tvalid && !has_space;
                if (flush && idx_reg != '0) state_next = ST_PAD;
            end
            ST_PAD: begin
                // Source samples are lost while padding; each counts as overflow.
                drop      = s_tvalid;
                wr_sample = '0;
                if (idx_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    wr_en = has_space;
                    if (has_space && is_last) state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end
`else
    always_comb begin
        wr_en     = s_tvalid && has_space;
        drop      = s_tvalid && !has_space;
        wr_sample = s_tdata;
    end
`endif

    // Shallow FIFO: asynchronous read gives first-word-fall-through with no extra latency.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_reg] <= {is_last, wr_sample};
    end

    assign rd_word = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            idx_reg          <= '0;
            active_log2n_reg <= NMAX_L;
            pend_log2n_reg   <= NMAX_L;
            pend_valid_reg   <= 1'b0;
            frame_cnt_reg    <= '0;
            ovf_cnt_reg      <= '0;
            ovf_pulse_reg    <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
                idx_reg    <= is_last ? '0 : idx_reg + LOG2_NMAX'(1);
            end
            if (rd_fire) rd_ptr_reg <= rd_ptr_reg + AW'(1);

            case ({wr_en, rd_fire})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase

            active_log2n_reg <= eff_log2n;
            if (cfg_load) begin
                pend_log2n_reg <= cfg_clamped;
                pend_valid_reg <= 1'b1;
            end else if (idx_reg == '0) begin
                pend_valid_reg <= 1'b0;
            end

            if (rd_fire && rd_word[IN_W]) frame_cnt_reg <= frame_cnt_reg + 16'd1;

            ovf_pulse_reg <= drop;
            if (drop && ovf_cnt_reg != 16'hFFFF) ovf_cnt_reg <= ovf_cnt_reg + 16'd1;
        end
    end

    generate
        for (genvar gi = 0; gi < OUT_W; gi++) begin : g_sext
            if (gi < IN_W) begin : g_bit
                assign re_ext[gi] = rd_word[gi];
            end else begin : g_sign
                assign re_ext[gi] = rd_word[IN_W-1];
            end
        end
    endgenerate

    assign m_tdata   = m_tvalid ? {{OUT_W{1'b0}}, re_ext} : '0;
    assign m_tlast   = m_tvalid && rd_word[IN_W];
    assign frame_cnt = frame_cnt_reg;
    assign ovf_cnt   = ovf_cnt_reg;
    assign ovf_pulse = ovf_pulse_reg;

endmodule

// File: tb/tb_fft_frame_packer.sv
// Directed + randomized bench for fft_frame_packer against a queue-based frame model.
module tb_fft_frame_packer;

    localparam int IN_W  = 8;
    localparam int OUT_W = 16;
    localparam int DEPTH = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        cfg_log2n;
    logic              cfg_load;
    logic              s_tvalid;
    logic [IN_W-1:0]   s_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic [2*OUT_W-1:0] m_tdata;
    logic              m_tlast;
    logic [15:0]       frame_cnt;
    logic [15:0]       ovf_cnt;
    logic              ovf_pulse;
`ifdef FRAME_FLUSH_EN
    logic              flush;
`endif

    fft_frame_packer dut (
        .clk(clk), .rst(rst),
`ifdef FRAME_FLUSH_EN
        .flush(flush),
`endif
        .cfg_log2n(cfg_log2n), .cfg_load(cfg_load),
        .s_tvalid(s_tvalid), .s_tdata(s_tdata),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .frame_cnt(frame_cnt), .ovf_cnt(ovf_cnt), .ovf_pulse(ovf_pulse)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: expected output stream as {last, sample} entries.
    logic [8:0] q[$];
    int  idx_m, n_m, pend_m, frames_m, ovf_m;
    bit  pend_v, pulse_m, pad_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [7:0] d);
        int s;
        s = $signed(d);
        return {16'h0000, s[15:0]};
    endfunction

    function automatic int clamp_l2n(input int l);
        if (l < 3)  return 3;
        if (l > 10) return 10;
        return l;
    endfunction

    task automatic model_drop();
        if (ovf_m < 65535) ovf_m++;
        pulse_m = 1'b1;
    endtask

    task automatic model_push(input logic [7:0] d);
        q.push_back({(idx_m == n_m - 1), d});
        idx_m = (idx_m + 1) % n_m;
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit rdy,
                        input bit load, input logic [3:0] l2n, input bit fl);
        bit rd, space;
        int idx_start;
        logic [8:0] popped;
        s_tvalid  = v;
        s_tdata   = d;
        m_tready  = rdy;
        cfg_load  = load;
        cfg_log2n = l2n;
`ifdef FRAME_FLUSH_EN
        flush     = fl;
`endif
        chk("m_tvalid", m_tvalid, q.size() > 0);
        if (q.size() > 0) begin
            chk("m_tdata", m_tdata, exp_word(q[0][7:0]));
            chk("m_tlast", m_tlast, q[0][8]);
        end

        rd        = (q.size() > 0) && rdy;
        space     = (q.size() < DEPTH) || rd;
        idx_start = idx_m;
        pulse_m   = 1'b0;
        if (pend_v && idx_m == 0) begin
            n_m    = 1 << pend_m;
            pend_v = 1'b0;
        end
        if (pad_m) begin
            if (v) model_drop();
            if (idx_m == 0) pad_m = 1'b0;
            else if (space) begin
                model_push(8'h00);
                if (idx_m == 0) pad_m = 1'b0;
            end
        end else begin
            if (v) begin
                if (space) model_push(d);
                else       model_drop();
            end
`ifdef FRAME_FLUSH_EN
            if (fl && idx_start != 0) pad_m = 1'b1;
`endif
        end
        if (load) begin
            pend_m = clamp_l2n(int'(l2n));
            pend_v = 1'b1;
        end
        if (rd) begin
            popped = q.pop_front();
            if (popped[8]) frames_m++;
        end

        @(posedge clk);
        #1;
        chk("ovf_pulse", ovf_pulse, pulse_m);
        chk("ovf_cnt", ovf_cnt, ovf_m[15:0]);
        chk("frame_cnt", frame_cnt, frames_m & 16'hFFFF);
    endtask

    task automatic do_reset();
        rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; cfg_load = 1'b0; cfg_log2n = '0; m_tready = 1'b0;
`ifdef FRAME_FLUSH_EN
        flush = 1'b0;
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        idx_m = 0; n_m = 1024; pend_m = 10; pend_v = 1'b0;
        frames_m = 0; ovf_m = 0; pulse_m = 1'b0; pad_m = 1'b0;
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_ovf_pulse", ovf_pulse, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_ovf_cnt", ovf_cnt, 0);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, rdy, 1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        // 1: N=8, samples 1..16 back to back, two frames
        do_reset();
        step(1'b0, 8'h00, 1'b1, 1'b1, 4'd3, 1'b0);
        for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b1, 1'b0, 4'd0, 1'b0);
        idle(3, 1'b1);
        chk("t1_frames", frame_cnt, 2);
        chk("t1_ovf", ovf_cnt, 0);

        // 2: sign extension at both extremes
        step(1'b1, 8'h80, 1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b1, 8'h7F, 1'b1, 1'b0, 4'd0, 1'b0);
        idle(3, 1'b1);

        // 3: stalled sink, 20 samples -> 16 buffered, 4 dropped, then drain
        for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 4'd0, 1'b0);
        chk("t3_ovf", ovf_cnt, 4);
        idle(18, 1'b1);

        // 4: length change requested mid-frame, then clamp from 15 down to 10
        do_reset();
        step(1'b0, 8'h00, 1'b1, 1'b1, 4'd3, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b1, 8'($urandom), 1'b1, 1'b1, 4'd4, 1'b0);
        for (int i = 0; i < 26; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b1, 8'($urandom), 1'b1, 1'b1, 4'd15, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0, 4'd0, 1'b0);
        idle(3, 1'b1);

        // 5: reset mid-frame restores the 1024-sample default length
        do_reset();
        step(1'b0, 8'h00, 1'b1, 1'b1, 4'd3, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0, 4'd0, 1'b0);
        do_reset();
        for (int i = 0; i < 1024; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0, 4'd0, 1'b0);
        idle(3, 1'b1);
        chk("t5_frames", frame_cnt, 1);

`ifdef FRAME_FLUSH_EN
        // 6: flush at idx=3 pads five zeros; samples during padding are dropped
        do_reset();
        step(1'b0, 8'h00, 1'b1, 1'b1, 4'd3, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0, 4'd0, 1'b0);
        idle(5, 1'b1);
        chk("t6_frames", frame_cnt, 1);
`endif

        // 7: random traffic with back-pressure and occasional length changes
        do_reset();
        step(1'b0, 8'h00, 1'b1, 1'b1, 4'd3, 1'b0);
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) < 8), 8'($urandom), ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 59) == 0), 4'($urandom_range(0, 7)), 1'b0);
        end
        idle(20, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
